// File: rtl/cond_flags_unit_if.sv
// Execute-stage condition unit bus: pipeline control and ALU flags in,
// gated side-effect enables and registered flags out.
interface cond_flags_unit_if;
    logic       ValidE;
    logic       StallE;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] ALUFlags;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       PCSrcE;
    logic       CondExE;
    logic       RegWriteGE;
    logic       MemWriteGE;
    logic       PCSrcGE;
    logic       CE;
    logic [3:0] FlagsE;

    modport master (
        output ValidE, StallE, CondE, FlagWriteE, ALUFlags, RegWriteE, MemWriteE, PCSrcE,
        input  CondExE, RegWriteGE, MemWriteGE, PCSrcGE, CE, FlagsE
    );

    modport slave (
        input  ValidE, StallE, CondE, FlagWriteE, ALUFlags, RegWriteE, MemWriteE, PCSrcE,
        output CondExE, RegWriteGE, MemWriteGE, PCSrcGE, CE, FlagsE
    );
endinterface

// File: rtl/cond_flags_unit.sv
// NZCV flags register, ARM condition-field evaluation and side-effect gating
// for the instruction currently in Execute.
module cond_flags_unit #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input logic               CLK,
    input logic               RESET,
    cond_flags_unit_if.slave  bus
);

    logic [3:0] r_flags;
    logic [3:0] w_flags_d;
    logic       w_cond_pass;
    logic       w_cond_ex;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Decode uses the registered flags only; ALUFlags never reaches CondExE.
    always_comb begin
        w_cond_pass = 1'b0;
        unique case (bus.CondE)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = !w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = !w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = !w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = !w_v;
            4'b1000: w_cond_pass = w_c && !w_z;
            4'b1001: w_cond_pass = !w_c || w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = !w_z && (w_n == w_v);
            4'b1101: w_cond_pass = w_z || (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            4'b1111: w_cond_pass = 1'b0;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign w_cond_ex = bus.ValidE & w_cond_pass;

    always_comb begin
        w_flags_d = r_flags;
        if (!bus.StallE) begin
            if (w_cond_ex && bus.FlagWriteE[1]) w_flags_d[3:2] = bus.ALUFlags[3:2];
            if (w_cond_ex && bus.FlagWriteE[0]) w_flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_flags <= FLAG_RESET;
        else       r_flags <= w_flags_d;
    end

    assign bus.CondExE    = w_cond_ex;
    assign bus.RegWriteGE = bus.RegWriteE & w_cond_ex;
    assign bus.MemWriteGE = bus.MemWriteE & w_cond_ex;
    assign bus.PCSrcGE    = bus.PCSrcE & w_cond_ex;
    assign bus.CE         = r_flags[1];
    assign bus.FlagsE     = r_flags;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed bench for cond_flags_unit: inputs change 1 time unit after the rising
// edge, outputs are checked mid-cycle well away from the next edge.
module tb_cond_flags_unit;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    cond_flags_unit_if bus ();

    cond_flags_unit #(.FLAG_RESET(4'b0000)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        RESET          = 1'b1;
        bus.ValidE     = 1'b0;
        bus.StallE     = 1'b0;
        bus.CondE      = 4'b0000;
        bus.FlagWriteE = 2'b00;
        bus.ALUFlags   = 4'b0000;
        bus.RegWriteE  = 1'b0;
        bus.MemWriteE  = 1'b0;
        bus.PCSrcE     = 1'b0;
        tick();
        tick();

        // Reset state, EQ against Z=0 during reset
        bus.CondE = 4'b0000; bus.ValidE = 1'b1; bus.RegWriteE = 1'b1;
        settle();
        check("rst_condex", {3'b0, bus.CondExE}, 4'b0000);
        check("rst_regwr", {3'b0, bus.RegWriteGE}, 4'b0000);
        check("rst_ce", {3'b0, bus.CE}, 4'b0000);
        check("rst_flags", bus.FlagsE, 4'b0000);
        RESET = 1'b0;

        // AL writes NZCV=0100, EQ passes next cycle
        bus.CondE = 4'b1110; bus.ALUFlags = 4'b0100; bus.FlagWriteE = 2'b11;
        bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b1;
        settle();
        check("al_condex", {3'b0, bus.CondExE}, 4'b0001);
        check("al_memwr", {3'b0, bus.MemWriteGE}, 4'b0001);
        tick();
        bus.CondE = 4'b0000; bus.FlagWriteE = 2'b00; bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b0;
        settle();
        check("c2_flags", bus.FlagsE, 4'b0100);
        check("eq_regwr", {3'b0, bus.RegWriteGE}, 4'b0001);
        bus.CondE = 4'b0001;
        settle();
        check("ne_condex", {3'b0, bus.CondExE}, 4'b0000);
        check("ne_regwr", {3'b0, bus.RegWriteGE}, 4'b0000);

        // Independent halves
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst2_flags", bus.FlagsE, 4'b0000);
        bus.CondE = 4'b1110; bus.FlagWriteE = 2'b01; bus.ALUFlags = 4'b1111;
        tick();
        check("cv_flags", bus.FlagsE, 4'b0011);
        check("cv_ce", {3'b0, bus.CE}, 4'b0001);
        bus.FlagWriteE = 2'b10;
        tick();
        check("nz_flags", bus.FlagsE, 4'b1111);

        // Signed conditions with N=1,V=1
        bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b1001; bus.CondE = 4'b1110;
        tick();
        bus.FlagWriteE = 2'b00;
        check("ld1001", bus.FlagsE, 4'b1001);
        bus.CondE = 4'b1010; settle(); check("ge_nv11", {3'b0, bus.CondExE}, 4'b0001);
        bus.CondE = 4'b1011; settle(); check("lt_nv11", {3'b0, bus.CondExE}, 4'b0000);
        bus.CondE = 4'b1100; settle(); check("gt_nv11", {3'b0, bus.CondExE}, 4'b0001);
        bus.CondE = 4'b1101; settle(); check("le_nv11", {3'b0, bus.CondExE}, 4'b0000);
        bus.CondE = 4'b0110; settle(); check("vs_nv11", {3'b0, bus.CondExE}, 4'b0001);

        // N=1,V=0
        bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b1000; bus.CondE = 4'b1110;
        tick();
        bus.FlagWriteE = 2'b00;
        check("ld1000", bus.FlagsE, 4'b1000);
        bus.CondE = 4'b1010; settle(); check("ge_n1", {3'b0, bus.CondExE}, 4'b0000);
        bus.CondE = 4'b1011; settle(); check("lt_n1", {3'b0, bus.CondExE}, 4'b0001);
        bus.CondE = 4'b0100; settle(); check("mi_n1", {3'b0, bus.CondExE}, 4'b0001);
        bus.CondE = 4'b0101; settle(); check("pl_n1", {3'b0, bus.CondExE}, 4'b0000);
        bus.CondE = 4'b1000; settle(); check("hi_c0", {3'b0, bus.CondExE}, 4'b0000);
        bus.CondE = 4'b1001; settle(); check("ls_c0", {3'b0, bus.CondExE}, 4'b0001);
        bus.CondE = 4'b0011; settle(); check("cc_c0", {3'b0, bus.CondExE}, 4'b0001);
        bus.CondE = 4'b1111; settle(); check("nv", {3'b0, bus.CondExE}, 4'b0000);

        // HI with C=1,Z=0 from F=0010 below; 3-cycle stall first
        bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b0010; bus.StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", bus.FlagsE, 4'b1000);
        end
        bus.StallE = 1'b0;
        tick();
        check("stall_rel", bus.FlagsE, 4'b0010);
        bus.FlagWriteE = 2'b00;
        bus.CondE = 4'b1000; settle(); check("hi_c1", {3'b0, bus.CondExE}, 4'b0001);
        bus.CondE = 4'b0010; settle(); check("cs_c1", {3'b0, bus.CondExE}, 4'b0001);

        // Reset wins over a write
        RESET = 1'b1; bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b1111;
        tick();
        RESET = 1'b0;
        check("rst_vs_wr", bus.FlagsE, 4'b0000);

        // Bubble blocks effects and flag writes
        bus.ValidE = 1'b0; bus.PCSrcE = 1'b1;
        settle();
        check("bub_pcsrc", {3'b0, bus.PCSrcGE}, 4'b0000);
        check("bub_condex", {3'b0, bus.CondExE}, 4'b0000);
        tick();
        check("bub_flags", bus.FlagsE, 4'b0000);
        bus.ValidE = 1'b1; bus.FlagWriteE = 2'b00;
        settle();
        check("val_pcsrc", {3'b0, bus.PCSrcGE}, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_flags_unit.md
# cond_flags_unit

Execute-stage condition unit of the pipelined ARMv3 core: holds the architectural NZCV flags register, evaluates the 4-bit condition field of the instruction in Execute against the current flags, and gates that instruction's side effects. It consumes the ALU's `ALUFlags` output and returns the registered carry to the ALU as `CE`.

## Interface
- `FLAG_RESET`, default 4'b0000, NZCV value loaded on reset.
- `CLK` input 1: single core clock, rising edge.
- `RESET` input 1: synchronous, active-high.
- `ValidE` input 1: Execute stage holds a real instruction, not a bubble.
- `StallE` input 1: Execute stage is held this cycle; the same instruction is presented again next cycle.
- `CondE` input 4: ARM condition field, bits [31:28].
- `FlagWriteE` input 2: [1] updates N,Z; [0] updates C,V. This is the S bit, split by class.
- `ALUFlags` input 4: {N,Z,C,V} from the ALU for the current instruction.
- `RegWriteE`, `MemWriteE`, `PCSrcE` input 1 each: ungated control bits.
- `CondExE` output 1: the condition passed and `ValidE` is high.
- `RegWriteGE`, `MemWriteGE`, `PCSrcGE` output 1 each: inputs ANDed with `CondExE`.
- `CE` output 1: registered C flag, fed to the ALU carry input.
- `FlagsE` output 4: registered {N,Z,C,V}, for debug and trace.

## Operation
- State: 4-bit flags register `F = {N,Z,C,V}`. There is no other state.
- Condition decode is combinational on `F`, not on `ALUFlags`:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 NV 0 (ARMv3 "never").
- `CondExE = ValidE & condpass(CondE, F)`.
- Gated outputs equal their inputs ANDed with `CondExE`. `StallE` does not gate them: the pipeline control already suppresses effects while stalled.
- Flag update at the rising edge, with priority top to bottom:
  - `RESET` loads `F <= FLAG_RESET`.
  - `StallE` holds `F`.
  - If `CondExE & FlagWriteE[1]`: `N,Z <= ALUFlags[3:2]`.
  - If `CondExE & FlagWriteE[0]`: `C,V <= ALUFlags[1:0]`.
  - The two halves update independently, both in the same cycle if both bits are set.
- A failed condition or a bubble (`ValidE=0`) never writes flags, even if `FlagWriteE` is nonzero.
- `CE = F[1]` and `FlagsE = F`. Both are pure register outputs with no combinational path from `ALUFlags`.

## Timing
- Reset values: `F = FLAG_RESET`, so `CE = FLAG_RESET[1]` and `FlagsE = FLAG_RESET`. The combinational outputs follow the inputs during reset, evaluated against the reset flags.
- Latency:
  - `CondExE` and the gated outputs respond in the same cycle, within 0 cycles of `CondE`/`ValidE`.
  - Flags written by instruction i are visible to instruction i+1 in Execute on the next cycle. No bubble and no bypass are required.
- Stall: the flags are written exactly once per instruction, on the cycle it leaves Execute (`StallE=0`). A 3-cycle stall followed by release produces one update.
- `RESET` together with any write: reset wins.
- A flush is presented as `ValidE=0`. All gated outputs are then 0 and `F` is unchanged.
- Critical path: `F` → condition mux → `CondExE` → gate AND. No adder is in this block.

## Test plan
- Reset with `FLAG_RESET=0000`, then `CondE=0000` (EQ), `ValidE=1`, `RegWriteE=1` → `CondExE=0`, `RegWriteGE=0`, `CE=0`.
- Cycle 1: `ALUFlags=0100`, `FlagWriteE=11`, AL. Cycle 2: EQ with `RegWriteE=1` → `FlagsE=0100` in cycle 2 and `RegWriteGE=1`. Then NE → `CondExE=0`.
- Start from `F=0000` and apply `FlagWriteE=01`, `ALUFlags=1111` → `F=0011`, N/Z unchanged, `CE=1`. Next apply `FlagWriteE=10` → `F=1111`.
- Load `F=1001` (N=1,V=1). GE passes, LT fails, GT passes, LE fails. Then `F=1000` → GE fails, LT passes. NV always gives `CondExE=0`.
- Hold `StallE=1` for 3 cycles with `FlagWriteE=11` and `ALUFlags=0010` → `F` is unchanged during the stall and becomes `0010` only after the release edge. Assert `RESET` in the same cycle as a write → `F=FLAG_RESET`.
- Apply `ValidE=0`, `CondE=1110`, `FlagWriteE=11`, `PCSrcE=1` → `PCSrcGE=0` and `F` is unchanged.
